// File: rtl/decade_stopwatch_ctrl.sv
// Run/pause/clear controller for a cascaded chain of BCD digit counters.
// A prescaler divides the clock into count ticks, gated by an IDLE/RUN/PAUSE FSM.
module decade_stopwatch_ctrl #(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  clear,
   output logic [4*DIGITS-1:0]   count,
   output logic                  running,
   output logic                  tick,
   output logic                  overflow
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   state_t               state;
   state_t               stateNext;
   logic [PW-1:0]        prescale;
   logic                 advance;
   logic                 terminal;
   logic                 incr;
   logic [4*DIGITS-1:0]  countNext;
   logic                 carry;
   logic                 wrap;
   logic [3:0]           digit;

   // A stop arriving with start outside RUN wins, which leaves the state untouched.
   always_comb begin
      stateNext = state;
      if (clear) begin
         stateNext = IDLE;
      end else begin
         case (state)
            IDLE, PAUSE: if (start && !stop) stateNext = RUN;
            RUN:         if (stop) stateNext = PAUSE;
            default:     stateNext = IDLE;
         endcase
      end
   end

   // The prescaler only moves on RUN edges that are not being stopped or cleared.
   assign advance  = (state == RUN) && !stop && !clear;
   assign terminal = (prescale == PW'(PRESCALE - 1));
   assign incr     = advance && terminal;

   // Ripple the carry through the digits; a carry surviving the top digit is a wrap.
   always_comb begin
      countNext = count;
      carry     = incr;
      digit     = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         digit = count[4*i +: 4];
         if (carry) begin
            if (digit >= 4'd9) begin
               countNext[4*i +: 4] = 4'd0;
            end else begin
               countNext[4*i +: 4] = digit + 4'd1;
               carry               = 1'b0;
            end
         end
      end
      wrap = carry;
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         state    <= IDLE;
         prescale <= '0;
         count    <= '0;
         running  <= 1'b0;
         tick     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         state   <= stateNext;
         running <= (stateNext == RUN);
         tick    <= incr;
         if (advance) begin
            prescale <= terminal ? '0 : prescale + PW'(1);
         end
         if (incr) begin
            count <= countNext;
         end
         if (wrap) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_decade_stopwatch_ctrl.sv
// Scoreboard bench for decade_stopwatch_ctrl: an integer-valued reference model
// queues expected outputs per edge, a monitor pops and compares them.
module tb_decade_stopwatch_ctrl;

   localparam int D    = 2;
   localparam int P    = 3;
   localparam int MAXV = 100;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;

   logic           clk;
   logic           rst;
   logic           start;
   logic           stop;
   logic           clear;
   logic [4*D-1:0] count;
   logic           running;
   logic           tick;
   logic           overflow;

   typedef struct {
      logic [4*D-1:0] count;
      logic           running;
      logic           tick;
      logic           overflow;
   } exp_t;

   exp_t sbq[$];

   int testCount = 0;
   int failCount = 0;

   int mMode = M_IDLE;
   int mVal  = 0;
   int mPh   = 0;
   bit mOvf  = 0;
   bit mTck  = 0;

   decade_stopwatch_ctrl #(.DIGITS(D), .PRESCALE(P)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .stop     (stop),
      .clear    (clear),
      .count    (count),
      .running  (running),
      .tick     (tick),
      .overflow (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [4*D-1:0] toBcd(input int v);
      logic [4*D-1:0] b;
      int             rem;
      b   = '0;
      rem = v;
      for (int i = 0; i < D; i++) begin
         b[4*i +: 4] = 4'(rem % 10);
         rem         = rem / 10;
      end
      return b;
   endfunction

   // Reference model: the count is a plain integer modulo 10^D, advanced once per P run edges.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         mTck = 0;
         if (rst || clear) begin
            mMode = M_IDLE;
            mVal  = 0;
            mPh   = 0;
            mOvf  = 0;
         end else if (mMode == M_RUN) begin
            if (stop) begin
               mMode = M_PAUSE;
            end else if (mPh == P - 1) begin
               mPh  = 0;
               mVal = mVal + 1;
               mTck = 1;
               if (mVal == MAXV) begin
                  mVal = 0;
                  mOvf = 1;
               end
            end else begin
               mPh = mPh + 1;
            end
         end else if (start && !stop) begin
            mMode = M_RUN;
         end
         e.count    = toBcd(mVal);
         e.running  = (mMode == M_RUN);
         e.tick     = mTck;
         e.overflow = mOvf;
         sbq.push_back(e);
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            checkOutput("count",    32'(count),    32'(e.count));
            checkOutput("running",  32'(running),  32'(e.running));
            checkOutput("tick",     32'(tick),     32'(e.tick));
            checkOutput("overflow", 32'(overflow), 32'(e.overflow));
         end
      end
   end

   // Drives one command cycle, then holds all inputs low for the remaining n-1 cycles.
   task automatic applyStimulus(input logic r, input logic s, input logic p, input logic c, input int n);
      rst   = r;
      start = s;
      stop  = p;
      clear = c;
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      stop  = 1'b0;
      clear = 1'b0;
      repeat (n - 1) @(negedge clk);
   endtask

   initial begin
      int t;
      rst   = 1'b1;
      start = 1'b0;
      stop  = 1'b0;
      clear = 1'b0;
      @(negedge clk);

      applyStimulus(1, 0, 0, 0, 1);
      applyStimulus(1, 0, 0, 0, 30);

      applyStimulus(0, 1, 0, 0, 31);
      applyStimulus(0, 0, 1, 0, 10);
      applyStimulus(0, 1, 0, 0, 5);

      t = 0;
      while (t < 10 && !(mMode == M_RUN && mPh == P - 1)) begin
         applyStimulus(0, 0, 0, 0, 1);
         t++;
      end
      testCount++;
      if (!(mMode == M_RUN && mPh == P - 1)) begin
         failCount++;
         $display("[TB] FAIL terminal_wait: got phase %0d, expected %0d", mPh, P - 1);
      end
      applyStimulus(0, 0, 1, 0, 4);
      applyStimulus(0, 1, 1, 0, 3);
      applyStimulus(0, 1, 0, 0, 4);

      applyStimulus(0, 1, 0, 1, 3);
      applyStimulus(0, 1, 1, 0, 3);
      applyStimulus(0, 1, 0, 0, 310);

      applyStimulus(0, 0, 0, 1, 2);
      applyStimulus(0, 1, 0, 0, 1);
      t = 0;
      while (t < 40 && mVal != 5) begin
         applyStimulus(0, 0, 0, 0, 1);
         t++;
      end
      testCount++;
      if (mVal != 5) begin
         failCount++;
         $display("[TB] FAIL reach_five: got %0d, expected 5", mVal);
      end
      applyStimulus(1, 0, 0, 0, 3);

      for (int i = 0; i < 1500; i++) begin
         applyStimulus(logic'($urandom_range(199) == 0), logic'($urandom_range(9) == 0),
                       logic'($urandom_range(14) == 0), logic'($urandom_range(59) == 0), 1);
      end

      repeat (3) @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
